// File: rtl/datapath_pkg.sv
// Shared constants, ALU op encoding and instruction ROM for the single-cycle datapath.
// The optional slt support is controlled by DATAPATH_SLT_EN in datapath.sv.
package datapath_pkg;

  localparam int unsigned REG_W     = 32;
  localparam int unsigned NREGS     = 32;
  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned PC_W      = 12;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned MEM_AW    = 8;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluSlt
  } alu_op_e;

  // addi $1,$0,5 / addi $2,$0,7 / add $3,$1,$2 / sw $3,48($0)
  localparam logic [REG_W-1:0] ROM_0 = 32'h2001_0005;
  localparam logic [REG_W-1:0] ROM_1 = 32'h2002_0007;
  localparam logic [REG_W-1:0] ROM_2 = 32'h0022_1820;
  localparam logic [REG_W-1:0] ROM_3 = 32'hAC03_0030;

  function automatic logic [REG_W-1:0] rom_word(input logic [1:0] idx);
    logic [REG_W-1:0] word;
    case (idx)
      2'd0:    word = ROM_0;
      2'd1:    word = ROM_1;
      2'd2:    word = ROM_2;
      default: word = ROM_3;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/data_memory.sv
// 256 x 32-bit word-addressed data memory: combinational read, synchronous write,
// asynchronous clear of every word on reset.
module data_memory
  import datapath_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [MEM_AW-1:0] address,
  input  logic [REG_W-1:0]  write_data,
  input  logic              mem_write,
  output logic [REG_W-1:0]  read_data
);

  logic [REG_W-1:0] ram [0:MEM_DEPTH-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < MEM_DEPTH; k++) begin
        ram[k] <= '0;
      end
    end else if (mem_write) begin
      ram[address] <= write_data;
    end
  end

  assign read_data = ram[address];

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit register file: two asynchronous read ports, one synchronous write port.
// $0 is hardwired to zero; reads see the pre-edge value (no write-through).
module regfile
  import datapath_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] read_reg_1,
  input  logic [REG_AW-1:0] read_reg_2,
  input  logic [REG_AW-1:0] write_reg,
  input  logic [REG_W-1:0]  write_data,
  input  logic              reg_write,
  output logic [REG_W-1:0]  read_data_1,
  output logic [REG_W-1:0]  read_data_2
);

  logic [REG_W-1:0] registers [0:NREGS-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NREGS; k++) begin
        registers[k] <= '0;
      end
    end else if (reg_write && (write_reg != '0)) begin
      registers[write_reg] <= write_data;
    end
  end

  assign read_data_1 = (read_reg_1 == '0) ? '0 : registers[read_reg_1];
  assign read_data_2 = (read_reg_2 == '0) ? '0 : registers[read_reg_2];

endmodule

// File: rtl/datapath.sv
// Single-cycle MIPS-subset datapath executing ROM[i] each clock; no output ports.
// Define DATAPATH_SLT_EN to build the signed slt comparator (funct 0x2A), else it is a NOP.
module datapath
  import datapath_pkg::*;
(
  input logic [1:0]      i,
  input logic            clock,
  input logic            reset,
  input logic [PC_W-1:0] pc
);

  logic [REG_W-1:0]  instr;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [REG_W-1:0]  imm_sext;

  logic              reg_write;
  logic              mem_write;
  logic              mem_to_reg;
  logic              alu_src;
  logic [REG_AW-1:0] write_reg;
  alu_op_e           alu_op;

  logic [REG_W-1:0]  rs_data;
  logic [REG_W-1:0]  rt_data;
  logic [REG_W-1:0]  operand_b;
  logic [REG_W-1:0]  alu_result;
  logic [REG_W-1:0]  write_data;
  logic [REG_W-1:0]  mem_read_data;
  logic [REG_W-1:0]  eff_addr;
  logic [MEM_AW-1:0] mem_addr;

  assign instr    = rom_word(i);
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};

  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    write_reg  = rd;
    alu_op     = AluAdd;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin reg_write = 1'b1; alu_op = AluAdd; end
          FN_SUB: begin reg_write = 1'b1; alu_op = AluSub; end
          FN_AND: begin reg_write = 1'b1; alu_op = AluAnd; end
          FN_OR:  begin reg_write = 1'b1; alu_op = AluOr;  end
`ifdef DATAPATH_SLT_EN
          FN_SLT: begin reg_write = 1'b1; alu_op = AluSlt; end
`endif
          default: ;
        endcase
      end
      OP_ADDI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        write_reg = rt;
      end
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
        write_reg  = rt;
      end
      OP_SW: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
      end
      default: ;
    endcase
  end

  assign operand_b = alu_src ? imm_sext : rt_data;

  always_comb begin
    alu_result = rs_data + operand_b;
    case (alu_op)
      AluSub: alu_result = rs_data - operand_b;
      AluAnd: alu_result = rs_data & operand_b;
      AluOr:  alu_result = rs_data | operand_b;
`ifdef DATAPATH_SLT_EN
      AluSlt: alu_result = {{(REG_W-1){1'b0}}, ($signed(rs_data) < $signed(operand_b))};
`endif
      default: ;
    endcase
  end

  // Data-segment base is applied only to memory addresses, not to the ALU result.
  assign eff_addr   = alu_result + {{(REG_W-PC_W){1'b0}}, pc};
  assign mem_addr   = eff_addr[MEM_AW-1:0];
  assign write_data = mem_to_reg ? mem_read_data : alu_result;

  regfile r2 (
    .clock       (clock),
    .reset       (reset),
    .read_reg_1  (rs),
    .read_reg_2  (rt),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .reg_write   (reg_write),
    .read_data_1 (rs_data),
    .read_data_2 (rt_data)
  );

  data_memory m1 (
    .clock      (clock),
    .reset      (reset),
    .address    (mem_addr),
    .write_data (rt_data),
    .mem_write  (mem_write),
    .read_data  (mem_read_data)
  );

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: expected architectural state is queued as each
// instruction is driven and checked against the register file and memory after the edge.
module tb_datapath;
  import datapath_pkg::*;

  logic [1:0]      i;
  logic            clock;
  logic            reset;
  logic [PC_W-1:0] pc;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    bit          is_mem;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  datapath dut (
    .i     (i),
    .clock (clock),
    .reset (reset),
    .pc    (pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] observe(input bit is_mem, input int idx);
    logic [7:0] a;
    logic [4:0] r;
    a = idx[7:0];
    r = idx[4:0];
    if (is_mem) return dut.m1.ram[a];
    return dut.r2.registers[r];
  endfunction

  task automatic exp_reg(input string tag, input int idx, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.is_mem = 1'b0; e.idx = idx; e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_mem(input string tag, input int idx, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.is_mem = 1'b1; e.idx = idx; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.is_mem, e.idx);
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input logic [1:0] iv, input logic [PC_W-1:0] pv);
    @(negedge clock);
    i  = iv;
    pc = pv;
    @(posedge clock);
    #1;
    drain();
  endtask

  initial begin
    i     = 2'd0;
    pc    = '0;
    reset = 1'b0;

    // Reset held across edges with i=0 driven: nothing may be written.
    repeat (2) @(posedge clock);
    #1;
    exp_reg("rst_r0", 0, 32'd0);
    exp_reg("rst_r1", 1, 32'd0);
    exp_reg("rst_r2", 2, 32'd0);
    exp_reg("rst_r3", 3, 32'd0);
    exp_mem("rst_m48", 48, 32'd0);
    drain();

    @(negedge clock);
    reset = 1'b1;

    exp_reg("seq0_r1", 1, 32'd5);
    step(2'd0, 12'd0);
    exp_reg("seq1_r2", 2, 32'd7);
    exp_reg("seq1_r1", 1, 32'd5);
    step(2'd1, 12'd0);
    exp_reg("seq2_r3", 3, 32'd12);
    step(2'd2, 12'd0);
    exp_mem("seq3_m48", 48, 32'd12);
    exp_mem("seq3_m52", 52, 32'd0);
    step(2'd3, 12'd0);

    for (int k = 0; k < 2; k++) begin
      exp_reg("hold_r1", 1, 32'd5);
      exp_reg("hold_r2", 2, 32'd7);
      exp_reg("hold_r3", 3, 32'd12);
      exp_mem("hold_m48", 48, 32'd12);
      step(2'd2, 12'd0);
    end

    // Asynchronous clear between edges, released before the next rising edge.
    #2;
    reset = 1'b0;
    #1;
    exp_reg("arst_r1", 1, 32'd0);
    exp_reg("arst_r2", 2, 32'd0);
    exp_reg("arst_r3", 3, 32'd0);
    exp_mem("arst_m48", 48, 32'd0);
    drain();
    #1;
    reset = 1'b1;

    exp_reg("pc4_r1", 1, 32'd5);
    step(2'd0, 12'd4);
    exp_reg("pc4_r2", 2, 32'd7);
    step(2'd1, 12'd4);
    exp_reg("pc4_r3", 3, 32'd12);
    step(2'd2, 12'd4);
    exp_mem("pc4_m52", 52, 32'd12);
    exp_mem("pc4_m48", 48, 32'd0);
    step(2'd3, 12'd4);

    // 48 + 0xFFF = 0x102F, truncated to word 0x2F.
    exp_mem("wrap_m47", 47, 32'd12);
    exp_mem("wrap_m52", 52, 32'd12);
    exp_mem("wrap_m48", 48, 32'd0);
    step(2'd3, 12'hFFF);

    // add $0,$1,$2 substituted for the ROM word: the write to $0 is discarded.
    @(negedge clock);
    force dut.instr = 32'h0022_0020;
    @(posedge clock);
    #1;
    exp_reg("zero_r0", 0, 32'd0);
    exp_reg("zero_r3", 3, 32'd12);
    exp_reg("zero_r1", 1, 32'd5);
    drain();
    @(negedge clock);
    release dut.instr;

    exp_reg("post_r0", 0, 32'd0);
    exp_reg("post_r3", 3, 32'd12);
    step(2'd2, 12'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL expose ports in positional order (i, clock, reset, pc); listed below clock and reset first.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 i  input  2  instruction select; indexes a 4-entry internal instruction ROM.
REQ-005 pc  input  12  data-segment base added to every data-memory effective address.
REQ-006 SHALL have no output ports; state is observed through the sub-module instances r2.registers[0:31] and m1.ram[0:255].

Function
REQ-007 Single-cycle operation: instr = ROM[i], decoded and executed combinationally; register/memory writes commit on the rising clock edge; one instruction per cycle.
REQ-008 ROM contents, 32-bit MIPS encoding: 0: addi $1,$0,5; 1: addi $2,$0,7; 2: add $3,$1,$2; 3: sw $3,48($0).
REQ-009 Supported ops: R-type (opcode 0) funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; addi 0x08; lw 0x23; sw 0x2B.
REQ-010 R-type writes rd; addi and lw write rt; sw writes no register.
REQ-011 Arithmetic is 32-bit two's complement; wrap-around, no overflow trap; slt is signed compare yielding 1 or 0.
REQ-012 Immediates are sign-extended to 32 bits.
REQ-013 Effective address = (rs + sext(imm) + zero-extended pc)[7:0]; word-addressed, 256 x 32-bit data memory.
REQ-014 lw reads memory combinationally and writes the result to rt on the edge; sw writes rt to memory on the edge.
REQ-015 Register $0 reads 0 always; writes to $0 are discarded.
REQ-016 Unknown opcode or funct: no register or memory write (NOP).
REQ-017 Register file internal signals are named read_reg_1, read_reg_2, write_reg, write_data and reg_write.
REQ-018 Same-cycle read-after-write: reads return the pre-edge value (no write-through bypass).

Reset
REQ-019 reset low SHALL immediately clear all 32 registers and all 256 memory words to 0, independent of clock.
REQ-020 While reset is low, no writes occur; execution resumes on the first rising edge after reset deasserts.
REQ-021 Reset asserted mid-operation overrides any same-edge write.

Configuration
REQ-022 Macro DATAPATH_SLT_EN: when defined, funct 0x2A performs slt; when undefined, funct 0x2A is a NOP (REQ-016) and no slt comparator is built.

Structure
REQ-023 Shared package datapath_pkg holds opcode/funct constants, ALU-op enum typedef, ROM contents, and widths (REG_W=32, NREGS=32, MEM_DEPTH=256, PC_W=12).
REQ-024 Register file is a separate sub-module (regfile, instance r2): two async read ports, one sync write port.
REQ-025 Data memory is a separate sub-module (data_memory, instance m1) holding array ram.
REQ-026 ALU and decode are inline in datapath.

Verification
REQ-027 reset=0 for one cycle -> registers[1..3]=0, ram[48]=0.
REQ-028 reset=1, pc=0, i=0,1,2,3 on consecutive edges -> r1=5, then r2=7, then r3=12, then ram[48]=12.
REQ-029 Repeat the sequence with pc=4 -> sw writes ram[52]=12; ram[48] stays 0.
REQ-030 Hold i=2 for two edges -> r3 remains 12, no other state change.
REQ-031 Pulse reset low between clock edges after r3=12 -> r1..r3 and ram[48] clear immediately, before the next edge.
REQ-032 Replace ROM entry 0 with add $0,$1,$2 in a bench build -> registers[0] stays 0.
